// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Machine-mode trap controller beside the MEM stage. Arbitrates
//            synchronous exceptions and NUM_IRQ maskable interrupts, owns the
//            M-mode CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval) and
//            drives pipeline flushes, writeback cancel and PC redirect.
// Ports    : clk, rst (async, active-high)
//            csr_rw_in / csr_wsc_mode_in / csr_addr_in / csr_wdata_in -> CSR op
//            csr_rdata_out   : combinational old value at csr_addr_in
//            irq_in          : level-sensitive interrupt lines
//            illegal_inst, l_access_fault, s_access_fault, ecall_m, fault_val
//            mret, epc_cur, epc_next
//            pc_redirect, redirect_valid, reg_{FD,DE,EM,MW}_flush,
//            RegWrite_cancel, busy
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int XLEN        = 32,
    parameter int NUM_IRQ     = 4,
    parameter bit VECTORED_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_rw_in,
    input  logic [1:0]        csr_wsc_mode_in,
    input  logic [11:0]       csr_addr_in,
    input  logic [XLEN-1:0]   csr_wdata_in,
    output logic [XLEN-1:0]   csr_rdata_out,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic              illegal_inst,
    input  logic              l_access_fault,
    input  logic              s_access_fault,
    input  logic              ecall_m,
    input  logic [XLEN-1:0]   fault_val,
    input  logic              mret,
    input  logic [XLEN-1:0]   epc_cur,
    input  logic [XLEN-1:0]   epc_next,
    output logic [XLEN-1:0]   pc_redirect,
    output logic              redirect_valid,
    output logic              reg_FD_flush,
    output logic              reg_DE_flush,
    output logic              reg_EM_flush,
    output logic              reg_MW_flush,
    output logic              RegWrite_cancel,
    output logic              busy
);

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MIE     = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_ADDR_MTVAL   = 12'h343;
    localparam logic [11:0] c_ADDR_MIP     = 12'h344;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    state_t r_state, w_state_next;

    // Only the architecturally writable bits are stored.
    logic               r_mstatus_mie, r_mstatus_mpie;
    logic [NUM_IRQ-1:0] r_mie, r_mip;
    logic [XLEN-1:0]    r_mtvec, r_mepc, r_mcause, r_mtval, r_target;

    logic [XLEN-1:0]    w_mstatus_rd, w_mie_rd, w_mip_rd;
    logic [XLEN-1:0]    w_wval, w_mtvec_wr, w_cause, w_target, w_tvec_base;
    logic [XLEN-1:0]    w_trap_epc, w_trap_tval;
    logic [NUM_IRQ-1:0] w_pend;
    logic [4:0]         w_exc_code, w_irq_code;
    logic               w_exc, w_idle, w_trap, w_mret_take, w_csr_we;

    // ---------------------------------------------------------------- reads
    always_comb begin
        w_mstatus_rd                = '0;
        w_mstatus_rd[3]             = r_mstatus_mie;
        w_mstatus_rd[7]             = r_mstatus_mpie;
        w_mie_rd                    = '0;
        w_mie_rd[16 +: NUM_IRQ]     = r_mie;
        w_mip_rd                    = '0;
        w_mip_rd[16 +: NUM_IRQ]     = r_mip;
    end

    always_comb begin
        case (csr_addr_in)
            c_ADDR_MSTATUS: csr_rdata_out = w_mstatus_rd;
            c_ADDR_MIE:     csr_rdata_out = w_mie_rd;
            c_ADDR_MTVEC:   csr_rdata_out = r_mtvec;
            c_ADDR_MEPC:    csr_rdata_out = r_mepc;
            c_ADDR_MCAUSE:  csr_rdata_out = r_mcause;
            c_ADDR_MTVAL:   csr_rdata_out = r_mtval;
            c_ADDR_MIP:     csr_rdata_out = w_mip_rd;
            default:        csr_rdata_out = '0;
        endcase
    end

    // ------------------------------------------------------- write datapath
    always_comb begin
        case (csr_wsc_mode_in)
            2'b01:   w_wval = csr_wdata_in;
            2'b10:   w_wval = csr_rdata_out | csr_wdata_in;
            2'b11:   w_wval = csr_rdata_out & ~csr_wdata_in;
            default: w_wval = csr_rdata_out;
        endcase
    end

    // Reserved mtvec modes (and vectored mode when disabled) collapse to direct.
    assign w_mtvec_wr = {w_wval[XLEN-1:2],
                         (w_wval[1:0] == 2'b01 && VECTORED_EN) ? 2'b01 : 2'b00};

    // ------------------------------------------------------- trap detection
    assign w_exc  = illegal_inst | l_access_fault | s_access_fault | ecall_m;
    assign w_pend = r_mip & r_mie & {NUM_IRQ{r_mstatus_mie}};
    assign w_idle = (r_state == ST_IDLE);
    assign w_trap = w_idle & (w_exc | (|w_pend));
    assign w_mret_take = w_idle & mret & ~w_trap;
    // A concurrent trap or MRET drops the CSR write.
    assign w_csr_we = w_idle & csr_rw_in & (csr_wsc_mode_in != 2'b00) & ~w_trap & ~mret;

    always_comb begin
        if (illegal_inst)        w_exc_code = 5'd2;
        else if (l_access_fault) w_exc_code = 5'd5;
        else if (s_access_fault) w_exc_code = 5'd7;
        else                     w_exc_code = 5'd11;
    end

    // Scan from the top so the lowest pending index is the last to assign.
    always_comb begin
        w_irq_code = 5'd16;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[i]) w_irq_code = 5'(16 + i);
        end
    end

    assign w_cause     = w_exc ? XLEN'(w_exc_code)
                               : {1'b1, {(XLEN-6){1'b0}}, w_irq_code};
    assign w_tvec_base = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_target    = (!w_exc && r_mtvec[1:0] == 2'b01)
                         ? w_tvec_base + (XLEN'(w_irq_code) << 2) : w_tvec_base;
    assign w_trap_epc  = w_exc ? {epc_cur[XLEN-1:2], 2'b00} : {epc_next[XLEN-1:2], 2'b00};
    assign w_trap_tval = (illegal_inst | l_access_fault | s_access_fault) ? fault_val : '0;

    // --------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next    = r_state;
        redirect_valid  = 1'b0;
        pc_redirect     = '0;
        reg_FD_flush    = 1'b0;
        reg_DE_flush    = 1'b0;
        reg_EM_flush    = 1'b0;
        reg_MW_flush    = 1'b0;
        RegWrite_cancel = 1'b0;
        busy            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trap) begin
                    w_state_next    = ST_REDIRECT;
                    reg_FD_flush    = 1'b1;
                    reg_DE_flush    = 1'b1;
                    reg_EM_flush    = 1'b1;
                    reg_MW_flush    = 1'b1;
                    // Interrupts let the MEM instruction retire.
                    RegWrite_cancel = w_exc;
                end else if (mret) begin
                    redirect_valid  = 1'b1;
                    pc_redirect     = r_mepc;
                    reg_FD_flush    = 1'b1;
                    reg_DE_flush    = 1'b1;
                    reg_EM_flush    = 1'b1;
                end
            end
            ST_REDIRECT: begin
                w_state_next   = ST_IDLE;
                redirect_valid = 1'b1;
                pc_redirect    = r_target;
                reg_FD_flush   = 1'b1;
                busy           = 1'b1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------- CSR state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mip          <= '0;
            r_mtvec        <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_target       <= '0;
        end else begin
            r_mip <= irq_in;
            if (w_trap) begin
                r_mepc         <= w_trap_epc;
                r_mcause       <= w_cause;
                r_mtval        <= w_trap_tval;
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
                r_target       <= w_target;
            end else if (w_mret_take) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (w_csr_we) begin
                case (csr_addr_in)
                    c_ADDR_MSTATUS: begin
                        r_mstatus_mie  <= w_wval[3];
                        r_mstatus_mpie <= w_wval[7];
                    end
                    c_ADDR_MIE:    r_mie    <= w_wval[16 +: NUM_IRQ];
                    c_ADDR_MTVEC:  r_mtvec  <= w_mtvec_wr;
                    c_ADDR_MEPC:   r_mepc   <= {w_wval[XLEN-1:2], 2'b00};
                    c_ADDR_MCAUSE: r_mcause <= w_wval;
                    c_ADDR_MTVAL:  r_mtval  <= w_wval;
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Self-checking bench for trap_ctrl: directed scenarios followed by
//            randomized traffic checked against a behavioural CSR/trap model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;
    localparam int XLEN        = 32;
    localparam int NUM_IRQ     = 4;
    localparam bit VECTORED_EN = 1'b1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              csr_rw_in;
    logic [1:0]        csr_wsc_mode_in;
    logic [11:0]       csr_addr_in;
    logic [31:0]       csr_wdata_in, csr_rdata_out;
    logic [NUM_IRQ-1:0] irq_in;
    logic              illegal_inst, l_access_fault, s_access_fault, ecall_m, mret;
    logic [31:0]       fault_val, epc_cur, epc_next, pc_redirect;
    logic              redirect_valid, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush;
    logic              RegWrite_cancel, busy;
    logic [31:0]       rv;

    int total = 0;
    int bad   = 0;

    logic [11:0] addr_tbl [8] = '{12'h300, 12'h304, 12'h305, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'h7C0};

    // Behavioural model state (architectural read values).
    logic [31:0] m_mstatus, m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_mip, m_target;
    logic        m_redir;

    trap_ctrl #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .VECTORED_EN(VECTORED_EN)) dut (
        .clk(clk), .rst(rst),
        .csr_rw_in(csr_rw_in), .csr_wsc_mode_in(csr_wsc_mode_in),
        .csr_addr_in(csr_addr_in), .csr_wdata_in(csr_wdata_in),
        .csr_rdata_out(csr_rdata_out), .irq_in(irq_in),
        .illegal_inst(illegal_inst), .l_access_fault(l_access_fault),
        .s_access_fault(s_access_fault), .ecall_m(ecall_m),
        .fault_val(fault_val), .mret(mret),
        .epc_cur(epc_cur), .epc_next(epc_next),
        .pc_redirect(pc_redirect), .redirect_valid(redirect_valid),
        .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
        .reg_EM_flush(reg_EM_flush), .reg_MW_flush(reg_MW_flush),
        .RegWrite_cancel(RegWrite_cancel), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] flushes();
        return {28'd0, reg_FD_flush, reg_DE_flush, reg_EM_flush, reg_MW_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // irq_in is deliberately left alone so interrupt lines can be held.
    task automatic clear_inputs();
        csr_rw_in = 1'b0; csr_wsc_mode_in = 2'b00; csr_addr_in = 12'h000;
        csr_wdata_in = 32'h0; illegal_inst = 1'b0; l_access_fault = 1'b0;
        s_access_fault = 1'b0; ecall_m = 1'b0; mret = 1'b0;
        fault_val = 32'h0; epc_cur = 32'h0; epc_next = 32'h0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
        @(negedge clk);
        clear_inputs();
        csr_rw_in = 1'b1; csr_addr_in = a; csr_wsc_mode_in = m; csr_wdata_in = d;
        @(posedge clk);
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        @(negedge clk);
        clear_inputs();
        csr_addr_in = a;
        #1;
        chk(tag, csr_rdata_out, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip;
            default: return 32'h0;
        endcase
    endfunction

    task automatic rand_cycle();
        logic [31:0] pend, nv, base, exp_pc, exp_fl;
        logic        exc, trap, exp_rv, exp_cancel, exp_busy;
        int          code;
        @(negedge clk);
        clear_inputs();
        illegal_inst   = ($urandom_range(0, 11) == 0);
        l_access_fault = ($urandom_range(0, 11) == 0);
        s_access_fault = ($urandom_range(0, 11) == 0);
        ecall_m        = ($urandom_range(0, 11) == 0);
        mret           = ($urandom_range(0, 7) == 0);
        csr_rw_in      = 1'($urandom_range(0, 1));
        csr_wsc_mode_in = 2'($urandom_range(0, 3));
        csr_addr_in    = addr_tbl[$urandom_range(0, 7)];
        csr_wdata_in   = ($urandom_range(0, 1) == 1) ? $urandom : 32'h0000_0088;
        if ($urandom_range(0, 3) == 0) irq_in = 4'($urandom_range(0, 15));
        epc_cur   = $urandom;
        epc_next  = $urandom;
        fault_val = $urandom;
        #1;
        exc  = illegal_inst | l_access_fault | s_access_fault | ecall_m;
        pend = m_mstatus[3] ? (m_mip & m_mie) : 32'h0;
        trap = !m_redir && (exc || pend != 0);
        exp_rv = 0; exp_pc = 0; exp_fl = 0; exp_cancel = 0; exp_busy = 0;
        if (m_redir) begin
            exp_rv = 1; exp_pc = m_target; exp_fl = 32'h8; exp_busy = 1;
        end else if (trap) begin
            exp_fl = 32'hF; exp_cancel = exc;
        end else if (mret) begin
            exp_rv = 1; exp_pc = m_mepc; exp_fl = 32'hE;
        end
        chk("rnd_rv",     {31'd0, redirect_valid},  {31'd0, exp_rv});
        chk("rnd_pc",     pc_redirect,              exp_pc);
        chk("rnd_flush",  flushes(),                exp_fl);
        chk("rnd_cancel", {31'd0, RegWrite_cancel}, {31'd0, exp_cancel});
        chk("rnd_busy",   {31'd0, busy},            {31'd0, exp_busy});
        chk("rnd_rdata",  csr_rdata_out,            m_read(csr_addr_in));
        // Model update for the coming edge.
        if (m_redir) begin
            m_redir = 0;
        end else if (trap) begin
            if (illegal_inst)        code = 2;
            else if (l_access_fault) code = 5;
            else if (s_access_fault) code = 7;
            else if (ecall_m)        code = 11;
            else begin
                code = 0;
                for (int i = NUM_IRQ - 1; i >= 0; i--)
                    if (pend[16 + i]) code = 16 + i;
            end
            m_mcause  = exc ? 32'(code) : (32'h8000_0000 | 32'(code));
            m_mepc    = (exc ? epc_cur : epc_next) & ~32'h3;
            m_mtval   = (illegal_inst | l_access_fault | s_access_fault) ? fault_val : 32'h0;
            base      = m_mtvec & ~32'h3;
            m_target  = (!exc && m_mtvec[1:0] == 2'b01) ? base + 32'(4 * code) : base;
            m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
            m_redir   = 1;
        end else if (mret) begin
            m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
        end else if (csr_rw_in && csr_wsc_mode_in != 2'b00) begin
            case (csr_wsc_mode_in)
                2'b01:   nv = csr_wdata_in;
                2'b10:   nv = m_read(csr_addr_in) | csr_wdata_in;
                default: nv = m_read(csr_addr_in) & ~csr_wdata_in;
            endcase
            case (csr_addr_in)
                12'h300: m_mstatus = nv & 32'h88;
                12'h304: m_mie     = nv & (((32'd1 << NUM_IRQ) - 1) << 16);
                12'h305: begin
                    if (nv[1:0] >= 2'd2 || (nv[1:0] == 2'd1 && !VECTORED_EN)) nv[1:0] = 2'b00;
                    m_mtvec = nv;
                end
                12'h341: m_mepc   = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval  = nv;
                default: ;
            endcase
        end
        m_mip = 32'(irq_in) << 16;
        @(posedge clk);
    endtask

    initial begin
        clear_inputs();
        irq_in = '0;

        // ---- reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_rv",     {31'd0, redirect_valid},  32'h0);
        chk("rst_busy",   {31'd0, busy},            32'h0);
        chk("rst_flush",  flushes(),                32'h0);
        chk("rst_cancel", {31'd0, RegWrite_cancel}, 32'h0);
        chk("rst_pc",     pc_redirect,              32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---- illegal instruction trap, direct mtvec
        csr_wr(12'h305, 2'b01, 32'h200);
        @(negedge clk);
        clear_inputs();
        illegal_inst = 1; epc_cur = 32'h100; fault_val = 32'hDEADBEEF;
        #1;
        chk("ill_T_flush",  flushes(), 32'hF);
        chk("ill_T_cancel", {31'd0, RegWrite_cancel}, 32'h1);
        chk("ill_T_rv",     {31'd0, redirect_valid},  32'h0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("ill_T1_rv",    {31'd0, redirect_valid}, 32'h1);
        chk("ill_T1_pc",    pc_redirect, 32'h200);
        chk("ill_T1_flush", flushes(), 32'h8);
        chk("ill_T1_busy",  {31'd0, busy}, 32'h1);
        @(posedge clk);
        rd_chk("ill_mepc",    12'h341, 32'h100);
        rd_chk("ill_mcause",  12'h342, 32'h2);
        rd_chk("ill_mtval",   12'h343, 32'hDEADBEEF);
        rd_chk("ill_mstatus", 12'h300, 32'h0);

        // ---- vectored interrupt on line 1 (line 2 also pending)
        csr_wr(12'h305, 2'b01, 32'h401);
        csr_wr(12'h304, 2'b01, 32'h0006_0000);
        @(negedge clk);
        clear_inputs();
        irq_in = 4'b0110;
        csr_rw_in = 1; csr_addr_in = 12'h300; csr_wsc_mode_in = 2'b01; csr_wdata_in = 32'h8;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        epc_next = 32'h84;
        #1;
        chk("irq_T_flush",  flushes(), 32'hF);
        chk("irq_T_cancel", {31'd0, RegWrite_cancel}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        irq_in = '0;
        #1;
        chk("irq_T1_rv", {31'd0, redirect_valid}, 32'h1);
        chk("irq_T1_pc", pc_redirect, 32'h444);
        @(posedge clk);
        rd_chk("irq_mepc",    12'h341, 32'h84);
        rd_chk("irq_mcause",  12'h342, 32'h8000_0011);
        rd_chk("irq_mstatus", 12'h300, 32'h80);

        // ---- MRET
        @(negedge clk);
        clear_inputs();
        mret = 1;
        #1;
        chk("mret_rv",    {31'd0, redirect_valid}, 32'h1);
        chk("mret_pc",    pc_redirect, 32'h84);
        chk("mret_flush", flushes(), 32'hE);
        chk("mret_busy",  {31'd0, busy}, 32'h0);
        @(posedge clk);
        rd_chk("mret_mstatus", 12'h300, 32'h88);

        // ---- ecall with a simultaneous mtvec write (write dropped)
        @(negedge clk);
        clear_inputs();
        ecall_m = 1; epc_cur = 32'h180; fault_val = 32'h1234_5678;
        csr_rw_in = 1; csr_addr_in = 12'h305; csr_wsc_mode_in = 2'b01; csr_wdata_in = 32'h300;
        #1;
        chk("ecall_T_flush",  flushes(), 32'hF);
        chk("ecall_T_cancel", {31'd0, RegWrite_cancel}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        #1;
        chk("ecall_T1_pc", pc_redirect, 32'h400);
        @(posedge clk);
        rd_chk("ecall_mtvec",  12'h305, 32'h401);
        rd_chk("ecall_mcause", 12'h342, 32'hB);
        rd_chk("ecall_mtval",  12'h343, 32'h0);
        rd_chk("ecall_mepc",   12'h341, 32'h180);

        // ---- CSR ops and masks
        csr_wr(12'h304, 2'b01, 32'hFFFF_FFFF);
        rd_chk("mie_mask", 12'h304, 32'h000F_0000);
        csr_wr(12'h300, 2'b10, 32'h88);
        rd_chk("mstatus_set", 12'h300, 32'h88);
        csr_wr(12'h300, 2'b11, 32'h88);
        rd_chk("mstatus_clr", 12'h300, 32'h0);
        csr_wr(12'h305, 2'b01, 32'h103);
        rd_chk("mtvec_mode3", 12'h305, 32'h100);
        csr_wr(12'h341, 2'b01, 32'h1237);
        rd_chk("mepc_align", 12'h341, 32'h1234);
        csr_wr(12'h7C0, 2'b01, 32'hFFFF_FFFF);
        rd_chk("unimpl_rd", 12'h7C0, 32'h0);
        csr_wr(12'h344, 2'b01, 32'hFFFF_FFFF);
        rd_chk("mip_ro", 12'h344, 32'h0);

        // ---- exception priority
        begin
            logic [3:0]  exc_tbl  [3] = '{4'b1110, 4'b0110, 4'b0011};
            logic [31:0] code_tbl [3] = '{32'd2, 32'd5, 32'd7};
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                clear_inputs();
                {illegal_inst, l_access_fault, s_access_fault, ecall_m} = exc_tbl[k];
                @(posedge clk);
                @(posedge clk);
                rd_chk("prio_mcause", 12'h342, code_tbl[k]);
            end
        end

        // ---- reset during REDIRECT
        @(negedge clk);
        clear_inputs();
        illegal_inst = 1;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        #1;
        chk("rstR_rv",   {31'd0, redirect_valid}, 32'h0);
        chk("rstR_busy", {31'd0, busy}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rstR_rv2", {31'd0, redirect_valid}, 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) rd_chk("rstR_csr", addr_tbl[k], 32'h0);

        // ---- randomized traffic against the model
        m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0;
        m_mtval = 0; m_mip = 0; m_target = 0; m_redir = 0;
        for (int n = 0; n < 400; n++) rand_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
